sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
Controller that sequences the MEM stage's data-memory accesses onto an external 16-bit asynchronous SRAM.
- Each 32-bit load or store becomes two 16-bit half-word accesses (low half, then high half), each with a programmable wait state.
- While an access is in flight the block drops ready; the top level uses ~ready to freeze every pipeline register and the PC.
- It sits between the MEM stage control and address outputs (MEM_R_EN, MEM_W_EN, ALU result, store value) and the board SRAM pins. It replaces the on-chip data memory.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 1, extra cycles each half-word access is held (0..7); each half lasts WAIT_CYCLES+1 cycles.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM half-word 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- MEM_R_EN  in  1  load request from MEM stage.
- MEM_W_EN  in  1  store request from MEM stage.
- address  in  32  CPU byte address (ALU result).
- writeData  in  32  store value.
- readData  out  32  load result.
- ready  out  1  1 = pipeline may advance; 0 = freeze.
- SRAM_ADDR  out  ADDR_W  SRAM half-word address.
- SRAM_DQ_out  out  16  write data to pad.
- SRAM_DQ_in  in  16  read data from pad.
- SRAM_DQ_oe  out  1  pad output enable.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_OE_N  out  1  active-low output enable.

Behaviour:
Clock and reset
- One clock domain (clk). rst is synchronous and active-high: it is sampled only on the rising edge of clk.

Request decode
- req = MEM_R_EN | MEM_W_EN.
- If both enables are high, the access is a write.
- wordIdx = (address - BASE_ADDR) >> 2, truncated to ADDR_W-1 bits; wraps modulo SRAM size.
- Low half address = {wordIdx, 0}; high half address = {wordIdx, 1}.

FSM states: IDLE, LO, HI, DONE; 3-bit wait counter cnt.
- IDLE: when req=1, latch op, address and writeData; go to LO with cnt=0.
- LO: drive the low-half address. When cnt==WAIT_CYCLES: on a read capture SRAM_DQ_in into lo_reg; go to HI with cnt=0. Otherwise cnt++.
- HI: same as LO for the high half, capturing into hi_reg; go to DONE.
- DONE: one cycle, then go to IDLE unconditionally. The pipeline advances on this edge, so the finished request is never re-accepted. A new request is first seen in the following IDLE cycle.

ready
- ready = (IDLE & ~req) | DONE. Combinational from state and req.

Latency
- Request first visible in cycle n: ready=0 in cycles n .. n+2*(WAIT_CYCLES+1); ready=1 in DONE at cycle n+2*(WAIT_CYCLES+1)+1.
- With WAIT_CYCLES=1: ready low for 5 cycles.

Read data
- On entering DONE, readData <= {hi_reg, lo_reg}, registered.
- readData holds its value until the next completed read; writes do not alter it.

SRAM pins
- Reads: SRAM_OE_N=0 and SRAM_DQ_oe=0 in LO/HI.
- Writes: SRAM_WE_N=0 and SRAM_DQ_oe=1 in LO/HI, except that SRAM_WE_N returns to 1 in the final cycle of each half. This gives an address/data hold edge; with WAIT_CYCLES=0 SRAM_WE_N stays low for the single cycle.
- SRAM_DQ_out = writeData[15:0] in LO and writeData[31:16] in HI.
- IDLE/DONE: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR holds its last value.

Reset values
- state=IDLE, cnt=0, readData=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1, SRAM_OE_N=1.
- ready follows its equation (1 if no request).
- Reset mid-access aborts immediately: strobes deassert on that edge and no partial readData update occurs.

Boundaries
- Request inputs changing during LO/HI are ignored because they are latched at IDLE.
- An address below BASE_ADDR wraps; no error is flagged.
- Byte/half stores are not supported; UB/LB pins are tied active at top level.

Test Plan:
- WAIT_CYCLES=1; SRAM model holds 0x1234 at half 0 and 0xABCD at half 1; LW of address 1024 in cycle n -> ready=0 cycles n..n+4, ready=1 at n+5, readData=0xABCD1234, SRAM_OE_N low 4 cycles, SRAM_ADDR 0,0,1,1.
- SW of 0xDEADBEEF to address 1032 -> SRAM half 4=0xBEEF, half 5=0xDEAD; SRAM_DQ_oe=1 only in LO/HI; ready pattern as for the read; readData unchanged.
- Back-to-back LW 1024 then LW 1028 (pipeline held by ready) -> two complete 5-cycle windows separated by exactly one ready=1 cycle; readData updates each time; no duplicate access.
- rst asserted in the second HI cycle of a store -> next cycle SRAM_WE_N=1, SRAM_DQ_oe=0, state IDLE, readData=0; a subsequent LW completes normally.
- WAIT_CYCLES=0 build; LW -> ready low 3 cycles, data correct. Also MEM_R_EN=MEM_W_EN=1 -> treated as a write.
- No requests for 20 cycles after reset -> ready=1 throughout; SRAM_WE_N=1 and SRAM_OE_N=1 constantly.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Splits each 32-bit MEM-stage load/store into low/high 16-bit async SRAM accesses of WAIT_CYCLES+1 cycles each.
// ready drops from the first request cycle until the DONE cycle (2*(WAIT_CYCLES+1)+1 cycles low) so the core freezes.
module sram_access_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_DQ_out,
  input  logic [15:0]       SRAM_DQ_in,
  output logic              SRAM_DQ_oe,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              wr_q;
  logic [ADDR_W-2:0] word_q;
  logic [31:0]       wdat_q;
  logic [15:0]       lo_q;
  logic [31:0]       rdat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       dq_out_q;
  logic              dq_oe_q;
  logic              we_n_q;
  logic              oe_n_q;

  logic              req;
  logic [31:0]       offset;
  logic [ADDR_W-2:0] word_idx;
  logic [2:0]        cnt_inc;
  logic              unused_offset_bits;

  assign req                = MEM_R_EN | MEM_W_EN;
  assign offset             = address - 32'(BASE_ADDR);
  assign word_idx           = offset[ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};
  assign cnt_inc            = cnt_q + 3'd1;

  // The write strobe releases one cycle before the address moves, except when a half is a single cycle.
  function automatic logic we_low(input logic [2:0] c);
    return (c != LAST_CNT) || (LAST_CNT == 3'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      word_q   <= '0;
      wdat_q   <= '0;
      lo_q     <= '0;
      rdat_q   <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q  <= S_LO;
            cnt_q    <= '0;
            wr_q     <= MEM_W_EN;
            word_q   <= word_idx;
            wdat_q   <= writeData;
            addr_q   <= {word_idx, 1'b0};
            dq_out_q <= writeData[15:0];
            dq_oe_q  <= MEM_W_EN;
            oe_n_q   <= MEM_W_EN;
            we_n_q   <= ~(MEM_W_EN & we_low(3'd0));
          end
        end
        S_LO: begin
          if (cnt_q == LAST_CNT) begin
            if (!wr_q) lo_q <= SRAM_DQ_in;
            state_q  <= S_HI;
            cnt_q    <= '0;
            addr_q   <= {word_q, 1'b1};
            dq_out_q <= wdat_q[31:16];
            we_n_q   <= ~(wr_q & we_low(3'd0));
          end else begin
            cnt_q  <= cnt_inc;
            we_n_q <= ~(wr_q & we_low(cnt_inc));
          end
        end
        S_HI: begin
          if (cnt_q == LAST_CNT) begin
            // High half is taken straight from the pad so readData is valid in DONE.
            if (!wr_q) rdat_q <= {SRAM_DQ_in, lo_q};
            state_q <= S_DONE;
            cnt_q   <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_inc;
            we_n_q <= ~(wr_q & we_low(cnt_inc));
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready       = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
  assign readData    = rdat_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_out = dq_out_q;
  assign SRAM_DQ_oe  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_OE_N   = oe_n_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances, each on its own SRAM pad model,
// checked cycle by cycle against a word-level reference memory.
module tb_sram_access_ctrl;
  localparam int ADDR_W = 18;
  localparam int BASE   = 1024;
  localparam int NWORDS = 1 << (ADDR_W - 1);
  localparam int NHALF  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_r_en   [2];
  logic              mem_w_en   [2];
  logic [31:0]       address    [2];
  logic [31:0]       write_data [2];
  logic [31:0]       read_data  [2];
  logic              ready      [2];
  logic [ADDR_W-1:0] sram_addr  [2];
  logic [15:0]       dq_out     [2];
  logic [15:0]       dq_in      [2];
  logic              dq_oe      [2];
  logic              we_n       [2];
  logic              oe_n       [2];

  logic [15:0] sram     [2][NHALF];
  logic [31:0] ref_word [2][NWORDS];
  logic [31:0] ref_rd   [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_w1 (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en[0]), .MEM_W_EN(mem_w_en[0]),
    .address(address[0]), .writeData(write_data[0]), .readData(read_data[0]), .ready(ready[0]),
    .SRAM_ADDR(sram_addr[0]), .SRAM_DQ_out(dq_out[0]), .SRAM_DQ_in(dq_in[0]),
    .SRAM_DQ_oe(dq_oe[0]), .SRAM_WE_N(we_n[0]), .SRAM_OE_N(oe_n[0])
  );

  sram_access_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_w0 (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en[1]), .MEM_W_EN(mem_w_en[1]),
    .address(address[1]), .writeData(write_data[1]), .readData(read_data[1]), .ready(ready[1]),
    .SRAM_ADDR(sram_addr[1]), .SRAM_DQ_out(dq_out[1]), .SRAM_DQ_in(dq_in[1]),
    .SRAM_DQ_oe(dq_oe[1]), .SRAM_WE_N(we_n[1]), .SRAM_OE_N(oe_n[1])
  );

  // Async SRAM: reads while OE_N is low, otherwise a recognisable junk pattern on the bus.
  for (genvar k = 0; k < 2; k++) begin : g_pad
    assign dq_in[k] = !oe_n[k] ? sram[k][sram_addr[k]] : 16'h5A5A;
  end

  function automatic logic [15:0] init_half(input int k, input int h);
    if (h == 0) return 16'h1234;
    if (h == 1) return 16'hABCD;
    return 16'((h * 40503) ^ (k * 7919) ^ (h >> 5));
  endfunction

  initial begin
    for (int k = 0; k < 2; k++)
      for (int h = 0; h < NHALF; h++) sram[k][h] = init_half(k, h);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        if (!we_n[k] && dq_oe[k]) sram[k][sram_addr[k]] = dq_out[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("idle_ready", 32'(ready[k]), 32'd1);
        chk("idle_we_n", 32'(we_n[k]), 32'd1);
        chk("idle_oe_n", 32'(oe_n[k]), 32'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Entered #1 after a rising edge with the DUT idle; returns the same way.
  task automatic access(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int rst_at);
    int w, last, widx, h, c;
    logic [31:0] old_rd, exp_rd;
    w      = (k == 0) ? 1 : 0;
    last   = 2 * (w + 1) + 1;
    widx   = int'(((a - 32'(BASE)) >> 2) & 32'(NWORDS - 1));
    old_rd = ref_rd[k];
    exp_rd = wr ? old_rd : ref_word[k][widx];
    mem_r_en[k]   = rd;
    mem_w_en[k]   = wr;
    address[k]    = a;
    write_data[k] = wd;
    for (int i = 0; i <= last; i++) begin
      if (i > 0) begin
        address[k]    = $urandom;
        write_data[k] = $urandom;
      end
      if (i == rst_at) rst = 1'b1;
      @(negedge clk);
      chk("ready", 32'(ready[k]), 32'(i == last));
      if (i >= 1 && i < last) begin
        h = (i - 1) / (w + 1);
        c = (i - 1) % (w + 1);
        chk("addr", 32'(sram_addr[k]), 32'(2 * widx + h));
        chk("oe_n", 32'(oe_n[k]), 32'(wr));
        chk("dq_oe", 32'(dq_oe[k]), 32'(wr));
        chk("we_n", 32'(we_n[k]), 32'(!(wr && (c != w || w == 0))));
        if (wr) chk("dq_out", 32'(dq_out[k]), 32'(h != 0 ? wd[31:16] : wd[15:0]));
        chk("rdata_hold", read_data[k], old_rd);
      end else begin
        chk("oe_n_idle", 32'(oe_n[k]), 32'd1);
        chk("we_n_idle", 32'(we_n[k]), 32'd1);
        chk("dq_oe_idle", 32'(dq_oe[k]), 32'd0);
      end
      if (i == last) begin
        chk("rdata", read_data[k], exp_rd);
        chk("addr_hold", 32'(sram_addr[k]), 32'(2 * widx + 1));
      end
      @(posedge clk);
      #1;
      if (i == rst_at) begin
        rst         = 1'b0;
        mem_r_en[k] = 1'b0;
        mem_w_en[k] = 1'b0;
        ref_rd[0]   = '0;
        ref_rd[1]   = '0;
        // Both write pulses end before the final HI cycle, so the word is fully stored.
        if (wr) ref_word[k][widx] = wd;
        @(negedge clk);
        chk("rst_ready", 32'(ready[k]), 32'd1);
        chk("rst_we_n", 32'(we_n[k]), 32'd1);
        chk("rst_oe_n", 32'(oe_n[k]), 32'd1);
        chk("rst_dq_oe", 32'(dq_oe[k]), 32'd0);
        chk("rst_rdata", read_data[k], 32'd0);
        chk("rst_addr", 32'(sram_addr[k]), 32'd0);
        @(posedge clk);
        #1;
        return;
      end
    end
    mem_r_en[k] = 1'b0;
    mem_w_en[k] = 1'b0;
    if (wr) begin
      ref_word[k][widx] = wd;
      chk("sram_lo", 32'(sram[k][2 * widx]), 32'(wd[15:0]));
      chk("sram_hi", 32'(sram[k][2 * widx + 1]), 32'(wd[31:16]));
    end else begin
      ref_rd[k] = exp_rd;
    end
  endtask

  initial begin
    logic        rd, wr;
    logic [31:0] a;
    int          k;
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      mem_r_en[j]   = 1'b0;
      mem_w_en[j]   = 1'b0;
      address[j]    = '0;
      write_data[j] = '0;
      ref_rd[j]     = '0;
      for (int wi = 0; wi < NWORDS; wi++)
        ref_word[j][wi] = {init_half(j, 2 * wi + 1), init_half(j, 2 * wi)};
    end

    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("reset_ready", 32'(ready[j]), 32'd1);
      chk("reset_rdata", read_data[j], 32'd0);
      chk("reset_addr", 32'(sram_addr[j]), 32'd0);
      chk("reset_dq_out", 32'(dq_out[j]), 32'd0);
      chk("reset_dq_oe", 32'(dq_oe[j]), 32'd0);
      chk("reset_we_n", 32'(we_n[j]), 32'd1);
      chk("reset_oe_n", 32'(oe_n[j]), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(20);

    access(0, 1'b1, 1'b0, 32'(BASE), 32'd0, -1);
    chk("lw_base", read_data[0], 32'hABCD1234);
    access(0, 1'b0, 1'b1, 32'(BASE + 8), 32'hDEADBEEF, -1);
    chk("sw_half4", 32'(sram[0][4]), 32'h0000BEEF);
    chk("sw_half5", 32'(sram[0][5]), 32'h0000DEAD);
    chk("sw_keeps_rdata", read_data[0], 32'hABCD1234);
    access(0, 1'b1, 1'b0, 32'(BASE), 32'd0, -1);
    access(0, 1'b1, 1'b0, 32'(BASE + 4), 32'd0, -1);
    idle_cycles(1);
    access(0, 1'b0, 1'b1, 32'(BASE + 16), 32'hCAFEF00D, 4);
    access(0, 1'b1, 1'b0, 32'(BASE + 16), 32'd0, -1);
    chk("lw_after_rst", read_data[0], 32'hCAFEF00D);

    access(1, 1'b1, 1'b0, 32'(BASE), 32'd0, -1);
    chk("w0_lw_base", read_data[1], 32'hABCD1234);
    access(1, 1'b1, 1'b1, 32'(BASE + 12), 32'h0BADC0DE, -1);
    chk("w0_both_en_keeps_rdata", read_data[1], 32'hABCD1234);
    access(1, 1'b1, 1'b0, 32'(BASE + 12), 32'd0, -1);
    chk("w0_both_en_stored", read_data[1], 32'h0BADC0DE);
    access(1, 1'b1, 1'b0, 32'(BASE - 4), 32'd0, -1);

    for (int n = 0; n < 60; n++) begin
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 7) == 0)
        a = 32'(BASE) - 32'(4 * $urandom_range(1, 16)) + 32'($urandom_range(0, 3));
      else
        a = 32'(BASE) + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      access(k, rd, wr, a, $urandom, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
